// File: rtl/card_init_ctrl_if.sv
// Board-initialisation bus: start request, generator link, game-logic write
// request and the register-file write port. The controller connects through the slave modport.
interface card_init_ctrl_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 5,
    parameter int N_W    = 5
);
    logic              start;
    logic [N_W-1:0]    num_cards;
    logic              gen_enable;
    logic [DATA_W-1:0] gen_data;
    logic              gl_wr_req;
    logic [ADDR_W-1:0] gl_wr_addr;
    logic [DATA_W-1:0] gl_wr_data;
    logic              gl_wr_gnt;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              busy;
    logic              ready;
    logic              err;

    modport slave (
        input  start, num_cards, gen_data, gl_wr_req, gl_wr_addr, gl_wr_data,
        output gen_enable, gl_wr_gnt, rf_wr_en, rf_wr_addr, rf_wr_data, busy, ready, err
    );

    modport master (
        output start, num_cards, gen_data, gl_wr_req, gl_wr_addr, gl_wr_data,
        input  gen_enable, gl_wr_gnt, rf_wr_en, rf_wr_addr, rf_wr_data, busy, ready, err
    );
endinterface

// File: rtl/card_init_ctrl.sv
// Board initialisation sequencer: runs the card generator, fills the card register file
// and arbitrates its write port. Optional build macro: CARD_CLEAR_UNUSED_EN.
module card_init_ctrl #(
    parameter int DATA_W    = 14,
    parameter int ADDR_W    = 5,
    parameter int N_W       = 5,
    parameter int MAX_CARDS = 12
) (
    input logic             clk,
    input logic             rst,
    card_init_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
`ifdef CARD_CLEAR_UNUSED_EN
        CLEAR,
`endif
        META,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [N_W-1:0]    n_q;
    logic [N_W-1:0]    cnt_q;
    logic [ADDR_W-1:0] widx_q;
    logic              vld_p1;
    logic              rf_en_p2;
    logic [ADDR_W-1:0] rf_addr_p2;
    logic [DATA_W-1:0] rf_data_p2;
    logic              err_q;

    logic accept, reject, gen_en, busy, ready, gnt, meta_wr, clr_wr;

    function automatic logic count_ok(input logic [N_W-1:0] n);
        return (n[0] == 1'b0) && (n >= N_W'(2)) && (n <= N_W'(MAX_CARDS));
    endfunction

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        gen_en  = 1'b0;
        busy    = 1'b0;
        ready   = 1'b0;
        gnt     = 1'b0;
        meta_wr = 1'b0;
        clr_wr  = 1'b0;
        case (state_q)
            IDLE, READY: begin
                ready = (state_q == READY);
                gnt   = bus.gl_wr_req;
                if (bus.start) begin
                    if (count_ok(bus.num_cards)) begin
                        accept  = 1'b1;
                        state_d = FILL;
                    end else begin
                        reject  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            FILL: begin
                gen_en = 1'b1;
                busy   = 1'b1;
                if (cnt_q == n_q - N_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
`ifdef CARD_CLEAR_UNUSED_EN
                state_d = (n_q == N_W'(MAX_CARDS)) ? META : CLEAR;
`else
                state_d = META;
`endif
            end
`ifdef CARD_CLEAR_UNUSED_EN
            CLEAR: begin
                busy   = 1'b1;
                clr_wr = 1'b1;
                if (widx_q == ADDR_W'(MAX_CARDS - 1)) state_d = META;
            end
`endif
            META: begin
                busy    = 1'b1;
                meta_wr = 1'b1;
                state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // stage p1: enable delayed to line up with the generator's one-cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            vld_p1 <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= reject;
            vld_p1 <= gen_en;
            if (accept)      cnt_q <= '0;
            else if (gen_en) cnt_q <= cnt_q + N_W'(1);
        end
    end

    // Write index counts card and clear writes; address is always index + 1.
    always_ff @(posedge clk) begin
        if (accept) begin
            n_q    <= bus.num_cards;
            widx_q <= '0;
        end else if (vld_p1 || clr_wr) begin
            widx_q <= widx_q + ADDR_W'(1);
        end
    end

    // stage p2: registered write port; card writes never overlap META/CLEAR or a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_p2   <= 1'b0;
            rf_addr_p2 <= '0;
            rf_data_p2 <= '0;
        end else if (vld_p1) begin
            rf_en_p2   <= 1'b1;
            rf_addr_p2 <= widx_q + ADDR_W'(1);
            rf_data_p2 <= bus.gen_data;
        end else if (clr_wr) begin
            rf_en_p2   <= 1'b1;
            rf_addr_p2 <= widx_q + ADDR_W'(1);
            rf_data_p2 <= '0;
        end else if (meta_wr) begin
            rf_en_p2   <= 1'b1;
            rf_addr_p2 <= '0;
            rf_data_p2 <= {{(DATA_W - N_W){1'b0}}, n_q};
        end else if (gnt) begin
            rf_en_p2   <= 1'b1;
            rf_addr_p2 <= bus.gl_wr_addr;
            rf_data_p2 <= bus.gl_wr_data;
        end else begin
            rf_en_p2   <= 1'b0;
        end
    end

    assign bus.gen_enable = gen_en;
    assign bus.gl_wr_gnt  = gnt;
    assign bus.rf_wr_en   = rf_en_p2;
    assign bus.rf_wr_addr = rf_addr_p2;
    assign bus.rf_wr_data = rf_data_p2;
    assign bus.busy       = busy;
    assign bus.ready      = ready;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_card_init_ctrl.sv
// Randomised bench for card_init_ctrl: a timing model of each game feeds a write
// scoreboard and per-cycle expectations that a negedge monitor checks.
module tb_card_init_ctrl;
    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 5;
    localparam int N_W       = 5;
    localparam int MAX_CARDS = 12;
`ifdef CARD_CLEAR_UNUSED_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_init_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_W(N_W)) cif ();

    card_init_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_W(N_W), .MAX_CARDS(MAX_CARDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cif)
    );

    typedef struct packed { int addr; int data; int cyc; } wr_t;
    typedef struct packed { int lo; int hi; } iv_t;

    wr_t sbq[$];
    iv_t gen_q[$], bsy_q[$], rdy_q[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_err  = 0;
    int  err_c  = -1;
    int  done_c = 0;
    bit  chk_en = 1'b0;
    bit  pat    = 1'b0;
    logic [DATA_W-1:0] cards [32];
    int  gidx    = 0;
    bit  prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: card k of the current run is presented the cycle after enable k.
    always @(posedge clk) begin
        if (cif.gen_enable) begin
            cif.gen_data <= cards[prev_en ? gidx[4:0] : 5'd0];
            gidx         <= prev_en ? gidx + 1 : 1;
        end
        prev_en <= cif.gen_enable;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_win(input iv_t q[$], input int c);
        foreach (q[i]) if (c >= q[i].lo && c <= q[i].hi) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_wr(input int a, input int d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        sbq.push_back(w);
    endtask

    function automatic iv_t mk_iv(input int lo, input int hi);
        iv_t v;
        v.lo = lo; v.hi = hi;
        return v;
    endfunction

    // Reference behaviour of a start sampled in cycle t.
    task automatic model_start(input int t, input int n);
        int m;
        if (in_win(bsy_q, t)) return;
        foreach (rdy_q[i]) if (rdy_q[i].hi > t) rdy_q[i].hi = t;
        if (n % 2 != 0 || n < 2 || n > MAX_CARDS) begin
            err_c = t + 1;
            return;
        end
        for (int k = 0; k < 32; k++)
            cards[k] = pat ? DATA_W'(32'h1000 + k) : DATA_W'($urandom);
        m = CLR ? MAX_CARDS : n;
        gen_q.push_back(mk_iv(t + 1, t + n));
        bsy_q.push_back(mk_iv(t + 1, t + m + 2));
        rdy_q.push_back(mk_iv(t + m + 3, 1 << 30));
        for (int k = 0; k < n; k++) push_wr(k + 1, int'(cards[k]), t + 3 + k);
        for (int a = n + 1; a <= m; a++) push_wr(a, 0, t + 2 + a);
        push_wr(0, n, t + m + 3);
        done_c = t + m + 3;
    endtask

    task automatic model_reset(input int c);
        foreach (gen_q[i]) if (gen_q[i].hi > c) gen_q[i].hi = c;
        foreach (bsy_q[i]) if (bsy_q[i].hi > c) bsy_q[i].hi = c;
        foreach (rdy_q[i]) if (rdy_q[i].hi > c) rdy_q[i].hi = c;
        for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].cyc > c) sbq.delete(i);
        if (err_c > c) err_c = -1;
        done_c = c;
    endtask

    always @(negedge clk) begin
        bit inb;
        int idx;
        if (chk_en) begin
            inb = in_win(bsy_q, cyc);
            chk("gen_enable", int'(cif.gen_enable), int'(in_win(gen_q, cyc)));
            chk("busy", int'(cif.busy), int'(inb));
            chk("ready", int'(cif.ready), int'(in_win(rdy_q, cyc)));
            chk("err", int'(cif.err), int'(cyc == err_c));
            chk("gl_wr_gnt", int'(cif.gl_wr_gnt), int'(cif.gl_wr_req && !inb));
            idx = -1;
            foreach (sbq[i]) if (sbq[i].cyc == cyc) idx = i;
            if (cif.rf_wr_en) begin
                if (idx < 0) begin
                    chk("rf_wr_unexpected", 1, 0);
                end else begin
                    chk("rf_wr_addr", int'(cif.rf_wr_addr), sbq[idx].addr);
                    chk("rf_wr_data", int'(cif.rf_wr_data), sbq[idx].data);
                    sbq.delete(idx);
                end
            end else if (idx >= 0) begin
                chk("rf_wr_missing", 0, 1);
                sbq.delete(idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic start_game(input int n);
        step();
        cif.start     = 1'b1;
        cif.num_cards = N_W'(n);
        model_start(cyc, n);
        step();
        cif.start     = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && cyc <= done_c; i++) step();
    endtask

    task automatic reset_pulse();
        step();
        rst = 1'b1;
        model_reset(cyc);
        step();
        rst = 1'b0;
    endtask

    task automatic gl_write(input int a, input int d);
        int g;
        bit got;
        step();
        cif.gl_wr_req  = 1'b1;
        cif.gl_wr_addr = ADDR_W'(a);
        cif.gl_wr_data = DATA_W'(d);
        g = cyc;
        foreach (bsy_q[i]) if (cyc >= bsy_q[i].lo && cyc <= bsy_q[i].hi) g = bsy_q[i].hi + 1;
        push_wr(a, d, g + 1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cif.gl_wr_gnt) got = 1'b1;
        end
        chk("gl_grant_cycle", got ? cyc : -1, g);
        step();
        cif.gl_wr_req = 1'b0;
    endtask

    task automatic start_with_write(input int n, input int a, input int d);
        step();
        cif.start      = 1'b1;
        cif.num_cards  = N_W'(n);
        cif.gl_wr_req  = 1'b1;
        cif.gl_wr_addr = ADDR_W'(a);
        cif.gl_wr_data = DATA_W'(d);
        push_wr(a, d, cyc + 1);
        model_start(cyc, n);
        step();
        cif.start     = 1'b0;
        cif.gl_wr_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int op;
        cif.start      = 1'b0;
        cif.num_cards  = '0;
        cif.gl_wr_req  = 1'b0;
        cif.gl_wr_addr = '0;
        cif.gl_wr_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rf_wr_en", int'(cif.rf_wr_en), 0);
        chk("reset_rf_wr_addr", int'(cif.rf_wr_addr), 0);
        chk("reset_rf_wr_data", int'(cif.rf_wr_data), 0);
        chk("reset_gen_enable", int'(cif.gen_enable), 0);
        chk("reset_busy", int'(cif.busy), 0);
        chk("reset_ready", int'(cif.ready), 0);
        chk("reset_err", int'(cif.err), 0);
        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Full board with the 0x1000+k card pattern
        pat = 1'b1;
        start_game(12);
        wait_done();
        pat = 1'b0;

        // Illegal counts, the first one issued from READY
        start_game(7);  idle(2);
        start_game(0);  idle(2);
        start_game(14); idle(2);
        start_game(31); idle(2);

        // Game-logic write stalled behind a fill
        start_game(6);
        idle(2);
        gl_write(3, int'($urandom_range(0, (1 << DATA_W) - 1)));
        wait_done();

        // Start during FILL is ignored
        start_game(10);
        idle(3);
        start_game(4);
        wait_done();

        // Reset in FILL cycle 5, then a fresh run
        start_game(12);
        idle(4);
        reset_pulse();
        idle(3);
        start_game(8);
        wait_done();

        // Start and write together in READY
        start_with_write(8, 5, int'($urandom_range(0, (1 << DATA_W) - 1)));
        wait_done();

        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    start_game(2 * int'($urandom_range(1, MAX_CARDS / 2)));
                    idle(int'($urandom_range(0, 20)));
                end
                1: begin
                    n = int'($urandom_range(0, 31));
                    if (n % 2 == 0 && n >= 2 && n <= MAX_CARDS) n = n + 1;
                    start_game(n);
                    idle(2);
                end
                2: gl_write(int'($urandom_range(0, 31)), int'($urandom_range(0, (1 << DATA_W) - 1)));
                default: idle(int'($urandom_range(1, 5)));
            endcase
        end
        wait_done();
        idle(4);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
